// File: rtl/crossbar_pkg.sv
// Shared definitions for the bus master and its crossbar neighbours.
//   state_t        : master FSM state encoding
//   DEF_DATA_WIDTH : default data bus width
//   DEF_ADDR_WIDTH : default address width (MSB = slave select)
//   DEF_TIMEOUT    : default ack wait limit in cycles
package crossbar_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RDATA = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fsm_master_if.sv
// Request/ack bus between the master and a crossbar or slave.
//   req   : master -> slave, transaction request (held until ack or timeout)
//   cmd   : master -> slave, 0 = read, 1 = write
//   addr  : master -> slave, MSB selects the slave, rest is the word address
//   wdata : master -> slave, write data
//   ack   : slave -> master, one-cycle acknowledge
//   rdata : slave -> master, read data, valid the cycle after a read ack
interface fsm_master_if #(
  parameter int DATA_WIDTH = crossbar_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = crossbar_pkg::DEF_ADDR_WIDTH
);

  logic                  req;
  logic                  cmd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, cmd, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, cmd, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/timeout_cnt.sv
// Ack wait counter for the bus master.
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : restart the count from zero (entry to the request state)
//   enable         : count one waited cycle
//   expired        : count has reached TIMEOUT-1
module timeout_cnt
  import crossbar_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] count;

  // Freezes once expired so a stray enable can never wrap it back to zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fsm_master.sv
// Single-transaction bus master: turns a local start strobe into one
// request/ack handshake on the bus, with a read-data capture cycle and an
// ack timeout. All outputs are registered.
//   clock, reset_n          : clock and asynchronous active-low reset
//   start                   : request a transaction (sampled in IDLE only)
//   op_cmd/op_addr/op_wdata : local operation, latched on start
//   busy                    : high outside IDLE
//   done, err               : one-cycle completion pulse, err = 1 on timeout
//   rd_data                 : last successful read result
//   bus                     : master side of the request/ack bus
module fsm_master
  import crossbar_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  op_cmd,
  input  logic [ADDR_WIDTH-1:0] op_addr,
  input  logic [DATA_WIDTH-1:0] op_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rd_data,
  fsm_master_if.master          bus
);

  state_t state;
  logic   tmo_clear;
  logic   tmo_enable;
  logic   tmo_expired;

  // The counter is zeroed on the same edge that enters REQ, so it reads 0
  // in the first request cycle and reaches TIMEOUT-1 in the last one.
  assign tmo_clear  = (state == ST_IDLE) && start;
  assign tmo_enable = (state == ST_REQ) && !bus.ack;

  timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bus.req   <= 1'b0;
      bus.cmd   <= 1'b0;
      bus.addr  <= '0;
      bus.wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_data   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_REQ;
            bus.req   <= 1'b1;
            bus.cmd   <= op_cmd;
            bus.addr  <= op_addr;
            bus.wdata <= op_wdata;
            busy      <= 1'b1;
            err       <= 1'b0;
          end
        end
        ST_REQ: begin
          // Ack is checked first so an ack on the expiry cycle still counts.
          if (bus.ack) begin
            bus.req <= 1'b0;
            if (bus.cmd) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RDATA;
            end
          end else if (tmo_expired) begin
            state   <= ST_DONE;
            bus.req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end
        end
        ST_RDATA: begin
          rd_data <= bus.rdata;
          done    <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          // start is deliberately not looked at here; it is picked up in IDLE.
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_master.sv
// Randomized self-checking bench for fsm_master. A transaction-level model
// predicts, from the ack delay chosen for each transaction, how long req is
// held, on which cycle done pulses, the err value and the read result.
module tb_fsm_master;
  import crossbar_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int TO = 16;
  localparam int NO_ACK = 255;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic          op_cmd;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] op_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] rd_data;

  fsm_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  fsm_master #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TO)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .op_cmd   (op_cmd),
    .op_addr  (op_addr),
    .op_wdata (op_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rd_data  (rd_data),
    .bus      (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  // Model state carried between transactions
  logic          exp_cmd   = 1'b0;
  logic [AW-1:0] exp_addr  = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic [DW-1:0] exp_rd    = '0;
  logic          exp_err   = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called just after a rising edge; each cycle is checked on the falling edge.
  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      start    = 1'b0;
      op_cmd   = 1'($urandom_range(0, 1));
      op_addr  = AW'($urandom);
      op_wdata = DW'($urandom);
      bus_if.ack   = 1'($urandom_range(0, 1));
      bus_if.rdata = DW'($urandom);
      @(negedge clock);
      check_eq("idle_req",   bus_if.req,   1'b0);
      check_eq("idle_busy",  busy,         1'b0);
      check_eq("idle_done",  done,         1'b0);
      check_eq("idle_err",   err,          exp_err);
      check_eq("idle_cmd",   bus_if.cmd,   exp_cmd);
      check_eq("idle_addr",  bus_if.addr,  exp_addr);
      check_eq("idle_wdata", bus_if.wdata, exp_wdata);
      check_eq("idle_rd",    rd_data,      exp_rd);
      @(posedge clock); #1;
    end
    bus_if.ack = 1'b0;
  endtask

  // One transaction. d = request cycle index (0-based) on which the slave acks;
  // d >= TO means the ack never lands inside the request window.
  // keep holds start high through the transaction; extra adds a second ack
  // pulse the cycle after the real one, which must be ignored.
  task automatic run_txn(input logic c, input logic [AW-1:0] a, input logic [DW-1:0] w,
                         input int d, input logic [DW-1:0] rval, input bit keep,
                         input bit extra, output int latency);
    bit ok;
    int req_cyc;
    int done_cyc;
    ok       = (d < TO);
    req_cyc  = ok ? d + 1 : TO;
    done_cyc = ok ? (c ? d + 2 : d + 3) : TO + 1;
    latency  = 0;

    start        = 1'b1;
    op_cmd       = c;
    op_addr      = a;
    op_wdata     = w;
    bus_if.ack   = 1'($urandom_range(0, 1));
    bus_if.rdata = DW'($urandom);
    @(negedge clock);
    check_eq("start_busy", busy,       1'b0);
    check_eq("start_req",  bus_if.req, 1'b0);
    check_eq("start_err",  err,        exp_err);
    @(posedge clock); #1;
    start     = keep;
    op_cmd    = 1'($urandom_range(0, 1));
    op_addr   = AW'($urandom);
    op_wdata  = DW'($urandom);
    exp_cmd   = c;
    exp_addr  = a;
    exp_wdata = w;

    for (int n = 1; n <= done_cyc; n++) begin
      bus_if.ack   = (n == d + 1) || (extra && (n == d + 2));
      bus_if.rdata = (n == d + 2) ? rval : DW'($urandom);
      @(negedge clock);
      if (!c && ok && n == done_cyc) exp_rd = rval;
      check_eq("req",     bus_if.req,   n <= req_cyc);
      check_eq("cmd",     bus_if.cmd,   exp_cmd);
      check_eq("addr",    bus_if.addr,  exp_addr);
      check_eq("wdata",   bus_if.wdata, exp_wdata);
      check_eq("busy",    busy,         1'b1);
      check_eq("done",    done,         n == done_cyc);
      check_eq("err",     err,          (n == done_cyc) && !ok);
      check_eq("rd_data", rd_data,      exp_rd);
      if (done === 1'b1) latency = n + 1;
      @(posedge clock); #1;
    end
    bus_if.ack = 1'b0;
    exp_err    = !ok;
  endtask

  // Reset pulse while the request is outstanding.
  task automatic reset_in_req();
    start        = 1'b1;
    op_cmd       = 1'b1;
    op_addr      = AW'($urandom);
    op_wdata     = DW'($urandom);
    bus_if.ack   = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check_eq("rst_pre_req", bus_if.req, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_req_async",  bus_if.req, 1'b0);
    check_eq("rst_busy_async", busy,       1'b0);
    @(posedge clock);
    @(negedge clock);
    check_eq("rst_no_done", done,       1'b0);
    check_eq("rst_req",     bus_if.req, 1'b0);
    check_eq("rst_addr",    bus_if.addr, '0);
    #2 reset_n = 1'b1;
    exp_cmd   = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
    exp_rd    = '0;
    exp_err   = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    start        = 1'b1;
    op_cmd       = 1'b1;
    op_addr      = AW'($urandom);
    op_wdata     = DW'($urandom);
    bus_if.ack   = 1'b1;
    bus_if.rdata = DW'($urandom);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_state_req",   bus_if.req,   1'b0);
    check_eq("rst_state_cmd",   bus_if.cmd,   1'b0);
    check_eq("rst_state_addr",  bus_if.addr,  '0);
    check_eq("rst_state_wdata", bus_if.wdata, '0);
    check_eq("rst_state_busy",  busy,         1'b0);
    check_eq("rst_state_done",  done,         1'b0);
    check_eq("rst_state_err",   err,          1'b0);
    check_eq("rst_state_rd",    rd_data,      '0);
    #2;
    reset_n    = 1'b1;
    start      = 1'b0;
    bus_if.ack = 1'b0;
    @(posedge clock); #1;
    idle_cycles(2);

    // Write with ack two cycles after req
    run_txn(1'b1, 4'h3, 32'hDEADBEEF, 2, '0, 1'b0, 1'b0, lat);
    check_eq("write_d2_latency", lat, 5);
    idle_cycles(1);

    // Immediate (registered) slave: write 4 cycles, read 5 cycles
    run_txn(1'b1, 4'hA, 32'h0BAD_F00D, 1, '0, 1'b0, 1'b0, lat);
    check_eq("write_latency", lat, 4);
    run_txn(1'b0, 4'h9, 32'h1234_5678, 1, 32'hA5A5_0001, 1'b0, 1'b0, lat);
    check_eq("read_latency", lat, 5);
    check_eq("read_result", rd_data, 32'hA5A5_0001);
    idle_cycles(2);

    // Timeout, then a normal transaction must start with err cleared
    run_txn(1'b0, 4'h5, 32'h0, NO_ACK, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
    check_eq("timeout_latency", lat, TO + 2);
    idle_cycles(1);
    run_txn(1'b1, 4'h6, 32'hCAFE_0006, 0, '0, 1'b0, 1'b0, lat);
    check_eq("after_timeout_latency", lat, 3);

    // Ack on the expiry cycle wins; a late ack in DONE is ignored
    run_txn(1'b1, 4'h7, 32'h7777_7777, TO - 1, '0, 1'b0, 1'b0, lat);
    run_txn(1'b0, 4'hE, 32'h0, TO - 1, 32'h5EED_0E0E, 1'b0, 1'b0, lat);
    run_txn(1'b1, 4'h2, 32'h2222_2222, TO, '0, 1'b0, 1'b0, lat);
    idle_cycles(2);

    // Reset in REQ, then normal operation
    reset_in_req();
    idle_cycles(2);
    run_txn(1'b0, 4'hC, 32'h0, 1, 32'h600D_0C0C, 1'b0, 1'b1, lat);
    check_eq("post_reset_read_latency", lat, 5);

    // Back-to-back with start held high
    run_txn(1'b1, 4'h1, 32'h1111_0001, 0, '0, 1'b1, 1'b1, lat);
    run_txn(1'b0, 4'h8, 32'h0, 0, 32'hB2B2_0002, 1'b1, 1'b1, lat);
    run_txn(1'b1, 4'hF, 32'hFFFF_0003, 1, '0, 1'b1, 1'b0, lat);
    idle_cycles(2);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      logic          c;
      logic [AW-1:0] a;
      logic [DW-1:0] w;
      logic [DW-1:0] rv;
      int            d;
      bit            keep;
      bit            extra;
      int            sel;
      c     = 1'($urandom_range(0, 1));
      a     = AW'($urandom);
      w     = DW'($urandom);
      rv    = DW'($urandom);
      sel   = $urandom_range(0, 9);
      if (sel < 7)       d = $urandom_range(0, 4);
      else if (sel < 9)  d = $urandom_range(TO - 2, TO);
      else               d = NO_ACK;
      keep  = ($urandom_range(0, 3) == 0);
      extra = ($urandom_range(0, 1) == 1);
      run_txn(c, a, w, d, rv, keep, extra, lat);
      if (!keep) idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fsm_master.md
FSM_MASTER -- requirements
Module: fsm_master

Interface
REQ-001 Parameter DATA_WIDTH, 32, data bus width in bits; SHALL be supported at 8..64.
REQ-002 Parameter ADDR_WIDTH, 4, address width in bits; the MSB selects the slave and the remaining bits are the word address.
REQ-003 Parameter TIMEOUT, 16, maximum cycles spent waiting for ack; SHALL be supported at 2..255.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  local strobe requesting one transaction; sampled only in IDLE.
REQ-007 op_cmd  in  1  local operation: 0 = read, 1 = write.
REQ-008 op_addr  in  ADDR_WIDTH  local address.
REQ-009 op_wdata  in  DATA_WIDTH  local write data.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse when a transaction completes (success or error).
REQ-012 err  out  1  valid with done; 1 = timeout.
REQ-013 rd_data  out  DATA_WIDTH  read result; holds its value until the next read completes.
REQ-014 req  out  1  bus request to the crossbar or slave.
REQ-015 cmd  out  1  bus command: 0 = read, 1 = write.
REQ-016 addr  out  ADDR_WIDTH  bus address.
REQ-017 wdata  out  DATA_WIDTH  bus write data.
REQ-018 ack  in  1  slave acknowledge; one-cycle pulse.
REQ-019 rdata  in  DATA_WIDTH  slave read data; valid only in the cycle after the ack of a read.

Function
REQ-020 States SHALL be IDLE, REQ, RDATA, DONE; every bus and local output SHALL be registered.
REQ-021 IDLE with start=1: latch op_cmd, op_addr and op_wdata into cmd, addr and wdata; go to REQ; req=1 from the next cycle.
REQ-022 IDLE with start=0: stay in IDLE with req=0; cmd, addr and wdata hold their last values.
REQ-023 REQ: req SHALL stay 1, and cmd, addr and wdata SHALL stay stable, until ack is sampled high or the timeout fires.
REQ-024 REQ with ack=1 and cmd=1: go to DONE; req=0 in the next cycle.
REQ-025 REQ with ack=1 and cmd=0: go to RDATA; req=0 in the next cycle.
REQ-026 RDATA: capture rdata into rd_data at the end of the cycle; go to DONE.
REQ-027 DONE: done=1 for exactly one cycle; err shows the result; go to IDLE. A start asserted during DONE SHALL be ignored.
REQ-028 Timeout counter: cleared on entry to REQ; increments each REQ cycle with ack=0; at TIMEOUT-1, set err=1, drop req, and go to DONE. An ack in the same cycle as the timeout SHALL win (normal completion).
REQ-029 An ack sampled outside REQ SHALL be ignored and SHALL NOT change state or outputs.
REQ-030 Latency, start to done, with an immediate-acking slave: write = 4 cycles, read = 5 cycles.
REQ-031 err SHALL be cleared when the next transaction starts.

Reset
REQ-032 While reset_n=0: state=IDLE; req, cmd, busy, done and err = 0; addr, wdata and rd_data = 0; timeout counter = 0.
REQ-033 Reset asserted mid-transaction SHALL abort immediately, with req=0 and no done pulse.

Structure
REQ-034 The state encoding and the default parameter values SHALL live in the shared package crossbar_pkg.
REQ-035 The timeout counter SHALL be a sub-module, timeout_cnt, with ports clear, enable and expired.

Verification
REQ-036 Write: op_addr=4'h3, op_wdata=32'hDEADBEEF, start=1, slave acks 2 cycles after req -> req held 3 cycles; bus carries addr=3 and wdata=DEADBEEF; done=1 with err=0.
REQ-037 Read: op_addr=4'h9; slave acks, then drives rdata=32'hA5A5_0001 in the next cycle -> rd_data=A5A50001 at done; total latency 5 cycles.
REQ-038 Timeout: no ack and TIMEOUT=16 -> req drops after 16 cycles; done=1 with err=1; the following transaction starts with err=0.
REQ-039 Ack in the same cycle as timeout expiry -> done=1 with err=0.
REQ-040 reset_n pulsed low while in REQ -> req=0 asynchronously; no done pulse; next start works normally.
REQ-041 Back-to-back: start held high continuously -> start ignored in DONE; second transaction begins one cycle after done; no spurious ack acceptance.
